// File: rtl/bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) for the four-digit display.
// Optional BCD_OVERFLOW_EN adds an overflow port and shows "EEEE" for values above 9999.
module bcd_converter #(
    parameter int WIDTH = 14
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic [3:0]       digit_1,
    output logic [3:0]       digit_2,
    output logic [3:0]       digit_3,
    output logic [3:0]       digit_4
`ifdef BCD_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [3:0] WIDTH_C = 4'(WIDTH);

    state_t           state_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [15:0]      scratch_q;
    logic [15:0]      scratch_d;
    logic [15:0]      adjusted;
    logic [3:0]       cnt_q;
    logic [15:0]      digits_q;
    logic             busy_q;
    logic             done_q;
`ifdef BCD_OVERFLOW_EN
    logic             pending_q;
    logic             overflow_q;
`endif

    // One double-dabble step; the bit leaving the thousands nibble is dropped (mod 10000).
    always_comb begin
        adjusted = scratch_q;
        for (int n = 0; n < 4; n++) begin
            if (scratch_q[4*n +: 4] >= 4'd5) begin
                adjusted[4*n +: 4] = scratch_q[4*n +: 4] + 4'd3;
            end
        end
        scratch_d = {adjusted[14:0], shift_q[WIDTH-1]};
        shift_d   = shift_q << 1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            digits_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef BCD_OVERFLOW_EN
            pending_q  <= 1'b0;
            overflow_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        shift_q   <= value;
                        scratch_q <= '0;
                        cnt_q     <= WIDTH_C;
                        busy_q    <= 1'b1;
                        state_q   <= SHIFT;
`ifdef BCD_OVERFLOW_EN
                        pending_q <= (32'(value) > 32'd9999);
`endif
                    end
                end
                SHIFT: begin
                    shift_q   <= shift_d;
                    scratch_q <= scratch_d;
                    cnt_q     <= cnt_q - 4'd1;
                    // Results load on the edge entering DONE so digits and done appear together.
                    if (cnt_q == 4'd1) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
`ifdef BCD_OVERFLOW_EN
                        if (pending_q) begin
                            digits_q   <= 16'hEEEE;
                            overflow_q <= 1'b1;
                        end else begin
                            digits_q   <= scratch_d;
                            overflow_q <= 1'b0;
                        end
`else
                        digits_q <= scratch_d;
`endif
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign digit_1 = digits_q[15:12];
    assign digit_2 = digits_q[11:8];
    assign digit_3 = digits_q[7:4];
    assign digit_4 = digits_q[3:0];
`ifdef BCD_OVERFLOW_EN
    assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_bcd_converter.sv
// Directed testbench for bcd_converter (WIDTH=14); honours BCD_OVERFLOW_EN when defined.
module tb_bcd_converter;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [13:0] value;
    logic        busy;
    logic        done;
    logic [3:0]  digit_1;
    logic [3:0]  digit_2;
    logic [3:0]  digit_3;
    logic [3:0]  digit_4;
`ifdef BCD_OVERFLOW_EN
    logic        overflow;
`endif

    int          assertCount = 0;
    int          failCount   = 0;
    logic [15:0] lastDigits  = 16'h0000;
    int          bad;

    bcd_converter #(.WIDTH(14)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .value   (value),
        .busy    (busy),
        .done    (done),
        .digit_1 (digit_1),
        .digit_2 (digit_2),
        .digit_3 (digit_3),
        .digit_4 (digit_4)
`ifdef BCD_OVERFLOW_EN
        ,
        .overflow(overflow)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] digits();
        return {digit_1, digit_2, digit_3, digit_4};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Holds start for one accepting edge, then scrambles value to prove it is not re-sampled.
    task automatic applyStimulus(input logic [13:0] v);
        start = 1'b1;
        value = v;
        tick(1);
        start = 1'b0;
        value = ~v;
    endtask

    // Returns at cycle t+15 having checked t+1..t+14 for busy, no done and frozen digits.
    task automatic runConversion(input string tag, input logic [13:0] v, input logic [15:0] expDigits);
        applyStimulus(v);
        bad = 0;
        for (int k = 1; k < 15; k++) begin
            if (busy !== 1'b1 || done !== 1'b0 || digits() !== lastDigits) bad++;
            tick(1);
        end
        checkOutput({tag, " midflight"}, bad, 0);
        checkOutput({tag, " done"}, {31'd0, done}, 1);
        checkOutput({tag, " busy@done"}, {31'd0, busy}, 1);
        checkOutput({tag, " digits"}, {16'd0, digits()}, {16'd0, expDigits});
        lastDigits = expDigits;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        value = '0;

        // Reset and convert zero
        tick(2);
        reset = 1'b1;
        checkOutput("reset busy", {31'd0, busy}, 0);
        checkOutput("reset done", {31'd0, done}, 0);
        checkOutput("reset digits", {16'd0, digits()}, 0);
`ifdef BCD_OVERFLOW_EN
        checkOutput("reset overflow", {31'd0, overflow}, 0);
`endif
        runConversion("zero", 14'd0, 16'h0000);
        tick(1);

        // 1234 with exact done/busy timing
        runConversion("1234", 14'd1234, 16'h1234);
        tick(1);
        checkOutput("1234 done low t+16", {31'd0, done}, 0);
        checkOutput("1234 busy low t+16", {31'd0, busy}, 0);
        checkOutput("1234 hold", {16'd0, digits()}, 32'h1234);

        // 9999 then back-to-back 7; start held during the DONE cycle is ignored
        runConversion("9999", 14'd9999, 16'h9999);
        start = 1'b1;
        value = 14'd7;
        tick(1);
        checkOutput("start in DONE ignored", {31'd0, busy}, 0);
        runConversion("7", 14'd7, 16'h0007);
        tick(1);

        // Start while busy is dropped, not queued
        applyStimulus(14'd56);
        tick(4);
        start = 1'b1;
        value = 14'd4321;
        tick(1);
        start = 1'b0;
        tick(9);
        checkOutput("56 done", {31'd0, done}, 1);
        checkOutput("56 digits", {16'd0, digits()}, 32'h0056);
        lastDigits = 16'h0056;
        tick(1);
        checkOutput("56 busy low t+16", {31'd0, busy}, 0);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (busy !== 1'b0 || done !== 1'b0) bad++;
            tick(1);
        end
        checkOutput("busy start not queued", bad, 0);

        // Reset mid-conversion aborts
        applyStimulus(14'd8888);
        tick(5);
        reset = 1'b0;
        tick(1);
        checkOutput("abort busy", {31'd0, busy}, 0);
        checkOutput("abort done", {31'd0, done}, 0);
        checkOutput("abort digits", {16'd0, digits()}, 0);
        reset = 1'b1;
        lastDigits = 16'h0000;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (done !== 1'b0 || busy !== 1'b0) bad++;
            tick(1);
        end
        checkOutput("abort no done", bad, 0);

        // Out-of-range values
`ifdef BCD_OVERFLOW_EN
        runConversion("12345 ovf", 14'd12345, 16'hEEEE);
        checkOutput("12345 overflow", {31'd0, overflow}, 1);
        tick(3);
        checkOutput("overflow holds", {31'd0, overflow}, 1);
        runConversion("42", 14'd42, 16'h0042);
        checkOutput("42 overflow", {31'd0, overflow}, 0);
        tick(1);
        runConversion("9999 edge", 14'd9999, 16'h9999);
        checkOutput("9999 overflow", {31'd0, overflow}, 0);
        tick(1);
        runConversion("10000 ovf", 14'd10000, 16'hEEEE);
        checkOutput("10000 overflow", {31'd0, overflow}, 1);
`else
        runConversion("12345 mod", 14'd12345, 16'h2345);
        tick(1);
        runConversion("10000 mod", 14'd10000, 16'h0000);
        tick(1);
        runConversion("16383 mod", 14'd16383, 16'h6383);
`endif
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
